// File: rtl/bsg_link_upstream_credit_arb.sv
// Round-robin arbiter that shares one upstream DDR link core port between NUM_REQ requesters and tracks decimated link credits.
// Optional packet lock: define BSG_LINK_ARB_PKT_LOCK_EN to hold the grant until the last flit of a packet.
module bsg_link_upstream_credit_arb #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 64,
    parameter int CREDITS       = 32,
    parameter int LG_DECIMATION = 3,
    localparam int CW           = $clog2(CREDITS + 1),
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     link_valid_o,
    output logic [WIDTH-1:0]         link_data_o,
    input  logic                     link_ready_i,
    input  logic                     token_i,
    output logic [CW-1:0]            credit_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     err_o
);

    logic               r_full;
    logic [WIDTH-1:0]   r_data;
    logic [NUM_REQ-1:0] r_grant;
    logic [CW-1:0]      r_credit;
    logic               r_err;
    logic [IDW-1:0]     r_ptr;

    logic               w_any;
    logic [IDW-1:0]     w_win_id;
    logic [WIDTH-1:0]   w_win_data;
    logic               w_accept;
    logic [IDW-1:0]     w_next_ptr;
    logic [CW:0]        w_credit_sum;
    logic               w_overflow;

`ifdef BSG_LINK_ARB_PKT_LOCK_EN
    logic               r_locked;
    logic [IDW-1:0]     r_lock_id;
`else
    logic               w_unused_last;
    assign w_unused_last = ^req_last_i;
`endif

    // Scan from the highest offset down so the lowest offset at or after the pointer wins.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_any      = 1'b0;
        w_win_id   = '0;
        w_win_data = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(r_ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid_i[idx]) begin
                w_any      = 1'b1;
                w_win_id   = IDW'(idx);
                w_win_data = req_data_i[idx*WIDTH +: WIDTH];
            end
        end
`ifdef BSG_LINK_ARB_PKT_LOCK_EN
        if (r_locked) begin
            w_any      = req_valid_i[r_lock_id];
            w_win_id   = r_lock_id;
            w_win_data = req_data_i[int'(r_lock_id)*WIDTH +: WIDTH];
        end
`endif
    end

    assign w_accept   = w_any && (r_credit != '0) && (!r_full || link_ready_i);
    assign w_next_ptr = (w_win_id == IDW'(NUM_REQ - 1)) ? '0 : w_win_id + IDW'(1);

    always_comb begin
        req_ready_o = '0;
        if (w_accept) req_ready_o = NUM_REQ'(1) << w_win_id;
    end

    // One extra bit holds credit + one token worth, so overflow is visible before saturation.
    assign w_credit_sum = {1'b0, r_credit} - (CW+1)'(w_accept)
                        + (token_i ? (CW+1)'(1 << LG_DECIMATION) : '0);
    assign w_overflow   = w_credit_sum > (CW+1)'(CREDITS);

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    // NOTE: the output data register is reset too, since link_data_o must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= 1'b0;
            r_data    <= '0;
            r_grant   <= '0;
            r_credit  <= CW'(CREDITS);
            r_err     <= 1'b0;
            r_ptr     <= '0;
`ifdef BSG_LINK_ARB_PKT_LOCK_EN
            r_locked  <= 1'b0;
            r_lock_id <= '0;
`endif
        end else begin
            if (w_overflow) begin
                r_credit <= CW'(CREDITS);
                r_err    <= 1'b1;
            end else begin
                r_credit <= w_credit_sum[CW-1:0];
            end

            if (w_accept) begin
                r_full  <= 1'b1;
                r_data  <= w_win_data;
                r_grant <= NUM_REQ'(1) << w_win_id;
`ifdef BSG_LINK_ARB_PKT_LOCK_EN
                if (req_last_i[w_win_id]) begin
                    r_locked <= 1'b0;
                    r_ptr    <= w_next_ptr;
                end else begin
                    r_locked  <= 1'b1;
                    r_lock_id <= w_win_id;
                end
`else
                r_ptr   <= w_next_ptr;
`endif
            end else if (r_full && link_ready_i) begin
                r_full  <= 1'b0;
                r_grant <= '0;
            end
        end
    end

    assign link_valid_o = r_full;
    assign link_data_o  = r_data;
    assign grant_o      = r_grant;
    assign credit_o     = r_credit;
    assign err_o        = r_err;

endmodule
